// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
package mem_arb_pkg;

  localparam int WORD_SIZE_DEF = 16;
  localparam int CNT_W         = 4;

  localparam logic REQ_INSTR = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Round-robin partner: the requester that did not win last time.
  function automatic logic other_req(input logic id);
    return (id == REQ_INSTR) ? REQ_DATA : REQ_INSTR;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// Memory latency counter: loaded on grant, counts down while strobes are held,
// and flags the final strobe cycle.
module mem_latency_counter
  import mem_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  // Load on grant, otherwise count down while the access is in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter for the single TSC memory port.
// Round-robin on contention, fixed-latency strobe sequencing, one-cycle ready.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WORD_SIZE   = WORD_SIZE_DEF,
  parameter int MEM_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ready,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ready,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 read_m,
  output logic                 write_m,
  output logic [WORD_SIZE-1:0] address,
  output logic [WORD_SIZE-1:0] m_wdata,
  input  logic [WORD_SIZE-1:0] m_rdata,
  output logic                 busy
);

  state_t               r_state;
  state_t               w_next;
  logic                 r_owner;
  logic                 r_last_grant;
  logic                 r_we;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata;
  logic [WORD_SIZE-1:0] r_d_rdata;

  logic                 w_grant;
  logic                 w_grant_owner;
  logic                 w_access;
  logic                 w_cnt_last;

  assign w_access = (r_state == ST_ACCESS);

  mem_latency_counter u_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_grant),
    .i_load_val (CNT_W'(MEM_LATENCY)),
    .i_dec      (w_access),
    .o_last     (w_cnt_last)
  );

  // Next-state and grant decision; grants are only made from IDLE.
  always_comb begin
    w_next        = r_state;
    w_grant       = 1'b0;
    w_grant_owner = REQ_INSTR;
    case (r_state)
      ST_IDLE: begin
        if (i_req && d_req) begin
          w_grant       = 1'b1;
          w_grant_owner = other_req(r_last_grant);
        end else if (d_req) begin
          w_grant       = 1'b1;
          w_grant_owner = REQ_DATA;
        end else if (i_req) begin
          w_grant       = 1'b1;
          w_grant_owner = REQ_INSTR;
        end
        if (w_grant) w_next = ST_ACCESS;
      end
      ST_ACCESS: if (w_cnt_last) w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // State register, request latches and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_owner      <= REQ_INSTR;
      r_last_grant <= REQ_INSTR;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_owner      <= w_grant_owner;
        r_last_grant <= w_grant_owner;
        r_we         <= (w_grant_owner == REQ_DATA) ? d_we : 1'b0;
        r_addr       <= (w_grant_owner == REQ_DATA) ? d_addr : i_addr;
        r_wdata      <= d_wdata;
      end
      // Writes leave the data read register untouched.
      if (w_access && w_cnt_last && !r_we) begin
        if (r_owner == REQ_DATA) r_d_rdata <= m_rdata;
        else                     r_i_rdata <= m_rdata;
      end
    end
  end

  assign read_m  = w_access & ~r_we;
  assign write_m = w_access & r_we;
  assign address = w_access ? r_addr  : '0;
  assign m_wdata = w_access ? r_wdata : '0;
  assign i_ready = (r_state == ST_RESP) && (r_owner == REQ_INSTR);
  assign d_ready = (r_state == ST_RESP) && (r_owner == REQ_DATA);
  assign i_rdata = r_i_rdata;
  assign d_rdata = r_d_rdata;
  assign busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LATENCY=2 plus
// fetch-only instances at MEM_LATENCY=1 and 5.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [15:0] i_addr, d_addr, d_wdata;
  logic        i_ready, d_ready, read_m, write_m, busy;
  logic [15:0] i_rdata, d_rdata, address, m_wdata, m_rdata;

  logic        z_bit;
  logic [15:0] z_word;
  logic        a1_req, a5_req;
  logic [15:0] a_addr;
  logic        a1_ready, a1_dready, a1_read_m, a1_write_m, a1_busy;
  logic [15:0] a1_rdata, a1_drdata, a1_address, a1_m_wdata, a1_m_rdata;
  logic        a5_ready, a5_dready, a5_read_m, a5_write_m, a5_busy;
  logic [15:0] a5_rdata, a5_drdata, a5_address, a5_m_wdata, a5_m_rdata;

  logic [15:0]  mem [0:255];
  logic [255:0] mem_v = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_init(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hF01C;
      8'h80:   return 16'hBEEF;
      8'h01:   return 16'h1111;
      default: return {8'hA5, a};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (write_m) begin
      mem[address[7:0]]   <= m_wdata;
      mem_v[address[7:0]] <= 1'b1;
    end
  end

  assign m_rdata    = mem_v[address[7:0]] ? mem[address[7:0]] : mem_init(address[7:0]);
  assign a1_m_rdata = mem_init(a1_address[7:0]);
  assign a5_m_rdata = mem_init(a5_address[7:0]);

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .read_m(read_m), .write_m(write_m), .address(address), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(a1_req), .i_addr(a_addr), .i_ready(a1_ready), .i_rdata(a1_rdata),
    .d_req(z_bit), .d_we(z_bit), .d_addr(z_word), .d_wdata(z_word),
    .d_ready(a1_dready), .d_rdata(a1_drdata),
    .read_m(a1_read_m), .write_m(a1_write_m), .address(a1_address), .m_wdata(a1_m_wdata),
    .m_rdata(a1_m_rdata), .busy(a1_busy)
  );

  mem_port_arbiter #(.WORD_SIZE(16), .MEM_LATENCY(5)) dut_l5 (
    .clk(clk), .reset(reset),
    .i_req(a5_req), .i_addr(a_addr), .i_ready(a5_ready), .i_rdata(a5_rdata),
    .d_req(z_bit), .d_we(z_bit), .d_addr(z_word), .d_wdata(z_word),
    .d_ready(a5_dready), .d_rdata(a5_drdata),
    .read_m(a5_read_m), .write_m(a5_write_m), .address(a5_address), .m_wdata(a5_m_wdata),
    .m_rdata(a5_m_rdata), .busy(a5_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_owner;
    int   cnt1, cnt5, rdy1, rdy5, np1, np5;

    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0;
    z_bit = 1'b0; z_word = '0; a1_req = 1'b0; a5_req = 1'b0; a_addr = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {read_m, write_m}, 0);
    chk("rst_ready", {i_ready, d_ready}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_address", address, 0);
    reset = 1'b0;

    // Single fetch
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    chk("f_read_m1", read_m, 1);
    chk("f_write_m1", write_m, 0);
    chk("f_addr1", address, 16'h0010);
    chk("f_busy1", busy, 1);
    tick();
    chk("f_read_m2", read_m, 1);
    chk("f_noready2", i_ready, 0);
    tick();
    chk("f_ready", i_ready, 1);
    chk("f_rdata", i_rdata, 16'hF01C);
    chk("f_read_m3", read_m, 0);
    i_req = 1'b0;
    tick();
    chk("f_idle", busy, 0);
    chk("f_ready_once", i_ready, 0);

    // Data write; inputs change after the grant
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
    tick();
    chk("w_write_m1", write_m, 1);
    chk("w_read_m1", read_m, 0);
    chk("w_wdata1", m_wdata, 16'h1234);
    chk("w_addr1", address, 16'h0040);
    d_wdata = 16'hFFFF; d_addr = 16'h0041;
    tick();
    chk("w_write_m2", write_m, 1);
    chk("w_wdata2", m_wdata, 16'h1234);
    chk("w_addr2", address, 16'h0040);
    tick();
    chk("w_ready", d_ready, 1);
    chk("w_d_rdata", d_rdata, 0);
    chk("w_write_m3", write_m, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();
    chk("w_idle", busy, 0);
    chk("w_mem", mem[8'h40], 16'h1234);

    // Contention after reset: data first
    reset = 1'b1; tick(); reset = 1'b0;
    i_req = 1'b1; i_addr = 16'h0001; d_req = 1'b1; d_addr = 16'h0080;
    tick();
    chk("c_addr_d", address, 16'h0080);
    chk("c_read_d", read_m, 1);
    tick(); tick();
    chk("c_dready", {i_ready, d_ready}, 2'b01);
    chk("c_drdata", d_rdata, 16'hBEEF);
    d_req = 1'b0;
    tick();
    chk("c_idle", busy, 0);
    tick();
    chk("c_addr_i", address, 16'h0001);
    chk("c_read_i", read_m, 1);
    tick(); tick();
    chk("c_iready", {i_ready, d_ready}, 2'b10);
    chk("c_irdata", i_rdata, 16'h1111);
    i_req = 1'b0;
    tick();
    chk("c_idle2", busy, 0);

    // Sustained contention: strict alternation, one access per 4 cycles
    i_addr = 16'h0020; d_addr = 16'h0030; i_req = 1'b1; d_req = 1'b1;
    exp_owner = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      chk("s_excl", read_m & write_m, 0);
      if ((k % 4) == 2) begin
        chk("s_ready", {i_ready, d_ready}, exp_owner ? 2'b01 : 2'b10);
        if (exp_owner) chk("s_drdata", d_rdata, 16'hA530);
        else           chk("s_irdata", i_rdata, 16'hA520);
        exp_owner = ~exp_owner;
      end else begin
        chk("s_noready", {i_ready, d_ready}, 2'b00);
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();
    chk("s_idle", busy, 0);

    // Reset in the middle of a read
    i_req = 1'b1; i_addr = 16'h0010;
    tick();
    chk("r_read_m", read_m, 1);
    reset = 1'b1; i_req = 1'b0;
    tick();
    chk("r_read_low", read_m, 0);
    chk("r_busy_low", busy, 0);
    chk("r_i_rdata", i_rdata, 0);
    chk("r_d_rdata", d_rdata, 0);
    reset = 1'b0;
    tick(); tick();
    chk("r_noready", {i_ready, d_ready}, 0);
    chk("r_idle", busy, 0);
    i_req = 1'b1; i_addr = 16'h0001;
    tick(); tick(); tick();
    chk("r_fetch_ready", i_ready, 1);
    chk("r_fetch_rdata", i_rdata, 16'h1111);
    i_req = 1'b0;
    tick();
    chk("r_fetch_idle", busy, 0);

    // Latency 1 and 5 builds
    a1_req = 1'b1; a5_req = 1'b1; a_addr = 16'h0010;
    cnt1 = 0; cnt5 = 0; rdy1 = -1; rdy5 = -1; np1 = 0; np5 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("l1_excl", a1_read_m & a1_write_m, 0);
      chk("l5_excl", a5_read_m & a5_write_m, 0);
      if (a1_read_m) cnt1++;
      if (a5_read_m) cnt5++;
      if (a1_ready) begin
        np1++;
        if (rdy1 < 0) rdy1 = k;
        chk("l1_rdata", a1_rdata, 16'hF01C);
        a1_req = 1'b0;
      end
      if (a5_ready) begin
        np5++;
        if (rdy5 < 0) rdy5 = k;
        chk("l5_rdata", a5_rdata, 16'hF01C);
        a5_req = 1'b0;
      end
    end
    chk("l1_strobe_width", cnt1, 1);
    chk("l5_strobe_width", cnt5, 5);
    chk("l1_ready_cycle", rdy1, 1);
    chk("l5_ready_cycle", rdy5, 5);
    chk("l1_pulses", np1, 1);
    chk("l5_pulses", np5, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port (read_m/write_m/address/data) between the instruction-fetch requester and the data-access requester of the 16-bit TSC CPU.
- Grants one access at a time, sequences the memory strobes for a fixed multi-cycle memory latency, and returns a one-cycle ready pulse with read data to the winning requester.
- Sits between the CPU core (fetch/mem-stage logic) and the memory model; the core no longer drives read_m/write_m directly.

Parameters:
- WORD_SIZE, 16, data and address width.
- MEM_LATENCY, 2, cycles the memory needs with strobes held (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_req  in  1  instruction-fetch request; held high until i_ready.
- i_addr  in  WORD_SIZE  fetch address.
- i_ready  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  WORD_SIZE  fetched word.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  WORD_SIZE  data address.
- d_wdata  in  WORD_SIZE  write data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  WORD_SIZE  read data (valid with d_ready on reads).
- read_m  out  1  memory read strobe.
- write_m  out  1  memory write strobe.
- address  out  WORD_SIZE  memory address.
- m_wdata  out  WORD_SIZE  memory write data.
- m_rdata  in  WORD_SIZE  memory read data, valid in last strobe cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sampled on clk edge): state IDLE, all outputs 0, i_rdata/d_rdata 0, cnt 0, last_grant = INSTR (so the first contention goes to data).
- States: IDLE, ACCESS, RESP.
- IDLE with no request: stay.
- IDLE with exactly one req: grant it.
- IDLE with both: grant the requester not equal to last_grant (round-robin). On grant, latch owner, addr, we and wdata into registers; cnt <= MEM_LATENCY; go to ACCESS; last_grant <= owner.
- ACCESS: address/m_wdata driven from latched registers. read_m = !we_q; write_m = we_q. Decrement cnt each cycle.
- ACCESS, cnt==1: capture m_rdata into owner's rdata register (reads only; writes leave d_rdata unchanged); go to RESP.
- RESP: strobes low; assert owner's ready for exactly this cycle; go to IDLE. No new grant in RESP.
- Timing: req sampled in IDLE at cycle t -> strobes high cycles t+1..t+MEM_LATENCY -> ready at t+MEM_LATENCY+1 -> IDLE at t+MEM_LATENCY+2. Back-to-back throughput is one access per MEM_LATENCY+2 cycles.
- Requester inputs may change after grant; the latched copies are used.
- Req dropped mid-access: access still completes and the ready pulse is still issued.
- Requester deasserts req in the cycle after its ready pulse. A req still high in the following IDLE cycle is a new request.
- read_m and write_m are never both high. Exactly one ready pulse per grant.
- Reset mid-ACCESS or mid-RESP: return to IDLE at that edge, strobes low, no ready pulse, rdata registers cleared.
- cnt width: 4 bits.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE/ACCESS/RESP, 2 bits);
  - requester id constants (REQ_INSTR=0, REQ_DATA=1);
  - WORD_SIZE default.
- One natural sub-module: mem_latency_counter (load MEM_LATENCY, decrement, last-cycle flag).
- The FSM, grant logic and latches stay in the top module.

Test Plan:
- Single fetch, MEM_LATENCY=2: i_req=1, i_addr=0x0010 at t, mem[0x0010]=0xF01C -> read_m=1, address=0x0010 at t+1,t+2; i_ready=1, i_rdata=0xF01C at t+3 only; busy low at t+4.
- Data write: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> write_m=1, read_m=0, m_wdata=0x1234 for 2 cycles; d_ready pulse; mem[0x0040]=0x1234; d_rdata unchanged.
- Contention after reset: i_req and d_req rise together, i_addr=0x0001, d_addr=0x0080 -> data served first (address=0x0080); fetch granted next IDLE, address=0x0001; two ready pulses, data first.
- Sustained contention over 6 accesses -> grants strictly alternate D,I,D,I,...; no requester waits more than one access.
- Reset mid-ACCESS (assert reset at t+1 of a read) -> read_m low and busy low next edge; no i_ready/d_ready pulse; a subsequent fetch completes normally.
- MEM_LATENCY=1 and =5 builds -> strobe width equals MEM_LATENCY; ready at t+MEM_LATENCY+1; read_m and write_m never high together (assertion).
